// File: rtl/mult_issue_sched.sv
// Multiply issue scheduler: round-robin arbitration of two requesters into the multiplier
// pipeline, credit/tag tracking of in-flight ops, and epoch-filtered writeback routing.
module mult_issue_sched #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned RD_W  = 6
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    REQ0_VALID,
  input  logic [31:0]             REQ0_OP1,
  input  logic [31:0]             REQ0_OP2,
  input  logic [1:0]              REQ0_CMD,
  input  logic [RD_W-1:0]         REQ0_RD,
  output logic                    REQ0_READY,
  input  logic                    REQ1_VALID,
  input  logic [31:0]             REQ1_OP1,
  input  logic [31:0]             REQ1_OP2,
  input  logic [1:0]              REQ1_CMD,
  input  logic [RD_W-1:0]         REQ1_RD,
  output logic                    REQ1_READY,
  output logic                    MULT_ISSUE,
  output logic [31:0]             MULT_OP1_SE,
  output logic [31:0]             MULT_OP2_SE,
  output logic [1:0]              MULT_CMD_RD,
  input  logic                    MULT_DONE,
  input  logic [31:0]             MULT_RES,
  input  logic                    FLUSH,
  output logic                    WB_VALID,
  output logic [RD_W-1:0]         WB_RD,
  output logic                    WB_SRC,
  output logic [31:0]             WB_DATA,
  output logic [$clog2(DEPTH):0]  INFLIGHT,
  output logic                    ERR
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [CW-1:0]   credits_q, credits_d;
  logic            rr_q, rr_d;
  logic            epoch_q, epoch_d;
  logic            err_q, err_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic            issue_q, issue_d;
  logic [31:0]     op1_q, op1_d;
  logic [31:0]     op2_q, op2_d;
  logic [1:0]      cmd_q, cmd_d;
  logic            wb_valid_q, wb_valid_d;
  logic [RD_W-1:0] wb_rd_q, wb_rd_d;
  logic            wb_src_q, wb_src_d;
  logic [31:0]     wb_data_q, wb_data_d;

  logic [RD_W-1:0] tag_rd_q  [DEPTH];
  logic            tag_src_q [DEPTH];
  logic            tag_ep_q  [DEPTH];

  logic can_issue, both_valid, gnt0, gnt1, accept, q_empty, pop;

  // Queue occupancy always equals DEPTH - credits, so no separate count is kept.
  always_comb begin
    can_issue  = (credits_q != '0) && !FLUSH;
    both_valid = REQ0_VALID && REQ1_VALID;
    gnt0       = can_issue && REQ0_VALID && (!REQ1_VALID || !rr_q);
    gnt1       = can_issue && REQ1_VALID && (!REQ0_VALID || rr_q);
    accept     = gnt0 || gnt1;
    q_empty    = (credits_q == CW'(DEPTH));
    pop        = MULT_DONE && !q_empty;
  end

  always_comb begin
    credits_d  = credits_q;
    rr_d       = rr_q;
    epoch_d    = epoch_q ^ FLUSH;
    err_d      = err_q | (MULT_DONE && q_empty);
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    issue_d    = accept;
    op1_d      = op1_q;
    op2_d      = op2_q;
    cmd_d      = cmd_q;
    wb_valid_d = 1'b0;
    wb_rd_d    = wb_rd_q;
    wb_src_d   = wb_src_q;
    wb_data_d  = wb_data_q;

    if (can_issue && both_valid) begin
      rr_d = ~rr_q;
    end

    if (accept) begin
      op1_d    = gnt1 ? REQ1_OP1 : REQ0_OP1;
      op2_d    = gnt1 ? REQ1_OP2 : REQ0_OP2;
      cmd_d    = gnt1 ? REQ1_CMD : REQ0_CMD;
      wr_ptr_d = wr_ptr_q + PW'(1);
    end

    unique case ({accept, pop})
      2'b10:   credits_d = credits_q - CW'(1);
      2'b01:   credits_d = credits_q + CW'(1);
      default: credits_d = credits_q;
    endcase

    // Results from a stale epoch, or retiring during a flush, still return their credit.
    if (pop) begin
      rd_ptr_d   = rd_ptr_q + PW'(1);
      wb_valid_d = !FLUSH && (tag_ep_q[rd_ptr_q] == epoch_d);
    end

    if (wb_valid_d) begin
      wb_rd_d   = tag_rd_q[rd_ptr_q];
      wb_src_d  = tag_src_q[rd_ptr_q];
      wb_data_d = MULT_RES;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      credits_q  <= CW'(DEPTH);
      rr_q       <= 1'b0;
      epoch_q    <= 1'b0;
      err_q      <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      issue_q    <= 1'b0;
      op1_q      <= '0;
      op2_q      <= '0;
      cmd_q      <= '0;
      wb_valid_q <= 1'b0;
      wb_rd_q    <= '0;
      wb_src_q   <= 1'b0;
      wb_data_q  <= '0;
    end else begin
      credits_q  <= credits_d;
      rr_q       <= rr_d;
      epoch_q    <= epoch_d;
      err_q      <= err_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      issue_q    <= issue_d;
      op1_q      <= op1_d;
      op2_q      <= op2_d;
      cmd_q      <= cmd_d;
      wb_valid_q <= wb_valid_d;
      wb_rd_q    <= wb_rd_d;
      wb_src_q   <= wb_src_d;
      wb_data_q  <= wb_data_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        tag_rd_q[i]  <= '0;
        tag_src_q[i] <= 1'b0;
        tag_ep_q[i]  <= 1'b0;
      end
    end else if (accept) begin
      tag_rd_q[wr_ptr_q]  <= gnt1 ? REQ1_RD : REQ0_RD;
      tag_src_q[wr_ptr_q] <= gnt1;
      tag_ep_q[wr_ptr_q]  <= epoch_q;
    end
  end

  always_comb begin
    REQ0_READY  = gnt0;
    REQ1_READY  = gnt1;
    MULT_ISSUE  = issue_q;
    MULT_OP1_SE = op1_q;
    MULT_OP2_SE = op2_q;
    MULT_CMD_RD = cmd_q;
    WB_VALID    = wb_valid_q;
    WB_RD       = wb_rd_q;
    WB_SRC      = wb_src_q;
    WB_DATA     = wb_data_q;
    INFLIGHT    = CW'(DEPTH) - credits_q;
    ERR         = err_q;
  end

endmodule

// File: tb/tb_mult_issue_sched.sv
// Scoreboard bench for mult_issue_sched: directed scenarios plus randomized traffic
// checked against a queue-based reference model.
module tb_mult_issue_sched;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned RD_W  = 6;

  logic            clk, reset_n;
  logic            REQ0_VALID, REQ1_VALID, REQ0_READY, REQ1_READY;
  logic [31:0]     REQ0_OP1, REQ0_OP2, REQ1_OP1, REQ1_OP2;
  logic [1:0]      REQ0_CMD, REQ1_CMD;
  logic [RD_W-1:0] REQ0_RD, REQ1_RD;
  logic            MULT_ISSUE, MULT_DONE, FLUSH, WB_VALID, WB_SRC, ERR;
  logic [31:0]     MULT_OP1_SE, MULT_OP2_SE, MULT_RES, WB_DATA;
  logic [1:0]      MULT_CMD_RD;
  logic [RD_W-1:0] WB_RD;
  logic [2:0]      INFLIGHT;

  mult_issue_sched #(.DEPTH(DEPTH), .RD_W(RD_W)) dut (
    .clk(clk), .reset_n(reset_n),
    .REQ0_VALID(REQ0_VALID), .REQ0_OP1(REQ0_OP1), .REQ0_OP2(REQ0_OP2),
    .REQ0_CMD(REQ0_CMD), .REQ0_RD(REQ0_RD), .REQ0_READY(REQ0_READY),
    .REQ1_VALID(REQ1_VALID), .REQ1_OP1(REQ1_OP1), .REQ1_OP2(REQ1_OP2),
    .REQ1_CMD(REQ1_CMD), .REQ1_RD(REQ1_RD), .REQ1_READY(REQ1_READY),
    .MULT_ISSUE(MULT_ISSUE), .MULT_OP1_SE(MULT_OP1_SE), .MULT_OP2_SE(MULT_OP2_SE),
    .MULT_CMD_RD(MULT_CMD_RD), .MULT_DONE(MULT_DONE), .MULT_RES(MULT_RES),
    .FLUSH(FLUSH), .WB_VALID(WB_VALID), .WB_RD(WB_RD), .WB_SRC(WB_SRC),
    .WB_DATA(WB_DATA), .INFLIGHT(INFLIGHT), .ERR(ERR)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {logic [RD_W-1:0] rd; logic src; logic ep;} tag_t;
  typedef struct packed {logic [31:0] a; logic [31:0] b; logic [1:0] c;} iss_t;
  typedef struct packed {logic [RD_W-1:0] rd; logic src; logic [31:0] d;} wb_t;

  tag_t m_tags[$];
  iss_t exp_iss[$];
  wb_t  exp_wb[$];
  int   m_credits;
  bit   m_rr, m_ep, m_err;
  int   errors, checks;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_tags.delete();
    exp_iss.delete();
    exp_wb.delete();
    m_credits = DEPTH;
    m_rr = 1'b0;
    m_ep = 1'b0;
    m_err = 1'b0;
  endtask

  task automatic set_idle();
    REQ0_VALID = 0; REQ1_VALID = 0; MULT_DONE = 0; FLUSH = 0;
  endtask

  // Called at a negedge with inputs already driven; checks, advances the model, then
  // returns at the following negedge.
  task automatic cycle();
    int   winner;
    tag_t t;
    #1;
    winner = -1;
    if (m_credits > 0 && !FLUSH) begin
      if (REQ0_VALID && REQ1_VALID) winner = m_rr ? 1 : 0;
      else if (REQ0_VALID) winner = 0;
      else if (REQ1_VALID) winner = 1;
    end
    chk("req0_ready", REQ0_READY, winner == 0);
    chk("req1_ready", REQ1_READY, winner == 1);
    chk("inflight", INFLIGHT, DEPTH - m_credits);
    chk("err", ERR, m_err);
    if (winner == 0) begin
      exp_iss.push_back('{REQ0_OP1, REQ0_OP2, REQ0_CMD});
      m_tags.push_back('{REQ0_RD, 1'b0, m_ep});
    end else if (winner == 1) begin
      exp_iss.push_back('{REQ1_OP1, REQ1_OP2, REQ1_CMD});
      m_tags.push_back('{REQ1_RD, 1'b1, m_ep});
    end
    if (winner >= 0) begin
      m_credits--;
      if (REQ0_VALID && REQ1_VALID) m_rr = !m_rr;
    end
    if (FLUSH) m_ep = !m_ep;
    if (MULT_DONE) begin
      if (m_tags.size() == 0) m_err = 1'b1;
      else begin
        t = m_tags.pop_front();
        m_credits++;
        if (!FLUSH && t.ep == m_ep) exp_wb.push_back('{t.rd, t.src, MULT_RES});
      end
    end
    @(negedge clk);
  endtask

  // Each expectation must be met on the very next clock edge.
  always @(posedge clk) begin
    #1;
    if (reset_n) begin
      if (MULT_ISSUE || exp_iss.size() != 0) begin
        if (exp_iss.size() == 0) chk("issue_spurious", 1, 0);
        else begin
          iss_t e;
          e = exp_iss.pop_front();
          chk("issue_valid", MULT_ISSUE, 1);
          chk("issue_data", {MULT_OP1_SE, MULT_OP2_SE, MULT_CMD_RD}, e);
        end
      end
      if (WB_VALID || exp_wb.size() != 0) begin
        if (exp_wb.size() == 0) chk("wb_spurious", 1, 0);
        else begin
          wb_t w;
          w = exp_wb.pop_front();
          chk("wb_valid", WB_VALID, 1);
          chk("wb_data", {WB_RD, WB_SRC, WB_DATA}, w);
        end
      end
    end
  end

  task automatic req(input int which, input logic [31:0] a, input logic [31:0] b,
                     input logic [RD_W-1:0] rd);
    if (which == 0) begin
      REQ0_VALID = 1; REQ0_OP1 = a; REQ0_OP2 = b; REQ0_RD = rd;
      REQ0_CMD = 2'($urandom_range(0, 3));
    end else begin
      REQ1_VALID = 1; REQ1_OP1 = a; REQ1_OP2 = b; REQ1_RD = rd;
      REQ1_CMD = 2'($urandom_range(0, 3));
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 3 * DEPTH && m_tags.size() != 0; i++) begin
      set_idle();
      MULT_DONE = 1; MULT_RES = $urandom;
      cycle();
    end
    set_idle();
    cycle();
  endtask

  initial begin
    bit ok_flush;
    errors = 0; checks = 0;
    model_reset();
    reset_n = 0;
    set_idle();
    REQ0_OP1 = 0; REQ0_OP2 = 0; REQ0_CMD = 0; REQ0_RD = 0;
    REQ1_OP1 = 0; REQ1_OP2 = 0; REQ1_CMD = 0; REQ1_RD = 0; MULT_RES = 0;
    repeat (2) @(negedge clk);
    chk("rst_outputs", {MULT_ISSUE, WB_VALID, ERR, INFLIGHT, WB_DATA, MULT_OP1_SE}, 0);
    reset_n = 1;

    // Single op 7*6 -> 42 to rd 5
    REQ0_VALID = 1; REQ0_OP1 = 7; REQ0_OP2 = 6; REQ0_RD = 5; REQ0_CMD = 0;
    cycle();
    set_idle();
    cycle();
    MULT_DONE = 1; MULT_RES = 42;
    cycle();
    chk("t1_wb", {WB_VALID, WB_RD, WB_SRC, WB_DATA}, {1'b1, 6'd5, 1'b0, 32'd42});
    set_idle();
    cycle();

    // Dual requests until credits run out, then done+req1 in one cycle
    for (int i = 0; i < 5; i++) begin
      req(0, $urandom, $urandom, 6'(i));
      req(1, $urandom, $urandom, 6'(i + 8));
      cycle();
    end
    chk("t2_inflight", INFLIGHT, 4);
    set_idle();
    req(1, 11, 12, 6'd20);
    MULT_DONE = 1; MULT_RES = $urandom;
    cycle();
    MULT_DONE = 0;
    cycle();
    drain();

    // Flush kills in-flight results; new op afterwards writes back
    for (int i = 0; i < 3; i++) begin
      set_idle(); req(i % 2, $urandom, $urandom, 6'(30 + i)); cycle();
    end
    set_idle(); FLUSH = 1; cycle();
    drain();
    chk("t4_inflight", INFLIGHT, 0);
    req(0, 3, 4, 6'd9); cycle();
    set_idle(); MULT_DONE = 1; MULT_RES = 12; cycle();
    set_idle(); cycle();

    // Flush blocks a pending request
    req(0, 1, 2, 6'd1); FLUSH = 1; cycle();
    set_idle(); cycle();

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      set_idle();
      if ($urandom_range(0, 2) != 0) req(0, $urandom, $urandom, 6'($urandom));
      if ($urandom_range(0, 2) != 0) req(1, $urandom, $urandom, 6'($urandom));
      if (m_tags.size() != 0 && $urandom_range(0, 2) == 0) begin
        MULT_DONE = 1; MULT_RES = $urandom;
      end
      ok_flush = 1;
      foreach (m_tags[k]) if (m_tags[k].ep != m_ep) ok_flush = 0;
      if (ok_flush && $urandom_range(0, 29) == 0) FLUSH = 1;
      cycle();
    end
    drain();

    // Done with empty queue sets sticky ERR; async reset clears it at once
    MULT_DONE = 1; MULT_RES = 5; cycle();
    set_idle(); cycle(); cycle();
    chk("err_sticky", ERR, 1);
    req(0, 9, 9, 6'd2); cycle();
    set_idle();
    #3 reset_n = 0;
    model_reset();
    #1;
    chk("err_async_clr", {ERR, INFLIGHT, MULT_ISSUE, WB_VALID}, 0);
    @(negedge clk);
    reset_n = 1;
    repeat (3) cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
